// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: sequences fetch/decode/execute states, drives the
// datapath strobes, times out stalled memory accesses and counts retired instructions.
module multicycle_control #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond_eq,
  output logic        pc_write_cond_ne,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dest,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic [3:0]  state,
  output logic        illegal_op,
  output logic        bus_error,
  output logic        instr_done,
  output logic [15:0] instr_count
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_RD    = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WR    = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_ADDI_EXEC = 4'd10;
  localparam logic [3:0] S_ADDI_WB   = 4'd11;

  localparam logic [5:0] OP_R    = 6'b101101;
  localparam logic [5:0] OP_LW   = 6'b101110;
  localparam logic [5:0] OP_SW   = 6'b101111;
  localparam logic [5:0] OP_J    = 6'b110000;
  localparam logic [5:0] OP_BEQ  = 6'b110001;
  localparam logic [5:0] OP_BNE  = 6'b110010;
  localparam logic [5:0] OP_ADDI = 6'b110011;

  localparam logic [7:0] WAIT_LIMIT_W = 8'(WAIT_LIMIT);

  logic [3:0]  state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [15:0] instr_count_q, instr_count_d;

  logic [5:0] op;
  logic       is_r, is_lw, is_sw, is_j, is_beq, is_bne, is_addi;
  logic       mem_state, stalled, timeout, retire;
  logic       unused_opcode_bits;

  assign op                 = opcode[5:0];
  assign unused_opcode_bits = ^opcode[7:6];

  assign is_r    = (op == OP_R);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_j    = (op == OP_J);
  assign is_beq  = (op == OP_BEQ);
  assign is_bne  = (op == OP_BNE);
  assign is_addi = (op == OP_ADDI);

  // Only the three states that wait on memory can stall or time out.
  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign stalled   = mem_state && !mem_ready;
  assign timeout   = stalled && (wait_q == WAIT_LIMIT_W);

  assign retire = (state_q == S_MEM_WB) || (state_q == S_R_WB) || (state_q == S_BRANCH) ||
                  (state_q == S_JUMP) || (state_q == S_ADDI_WB) ||
                  ((state_q == S_MEM_WR) && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      wait_q        <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      instr_count_q <= instr_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_lw || is_sw)        state_d = S_MEM_ADDR;
        else if (is_r)             state_d = S_R_EXEC;
        else if (is_beq || is_bne) state_d = S_BRANCH;
        else if (is_j)             state_d = S_JUMP;
        else if (is_addi)          state_d = S_ADDI_EXEC;
        else                       state_d = S_FETCH;
      end
      S_MEM_ADDR: begin
        if (is_lw)      state_d = S_MEM_RD;
        else if (is_sw) state_d = S_MEM_WR;
        else            state_d = S_FETCH;
      end
      S_MEM_RD: begin
        if (mem_ready)    state_d = S_MEM_WB;
        else if (timeout) state_d = S_FETCH;
      end
      S_MEM_WR: begin
        if (mem_ready || timeout) state_d = S_FETCH;
      end
      S_R_EXEC:    state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      default:     state_d = S_FETCH;
    endcase

    // A timeout in FETCH keeps the state but must still restart the wait window.
    if (timeout || (state_d != state_q)) wait_d = '0;
    else if (stalled)                    wait_d = wait_q + 8'd1;
    else                                 wait_d = wait_q;

    instr_count_d = retire ? instr_count_q + 16'd1 : instr_count_q;
  end

  always_comb begin
    pc_write         = 1'b0;
    pc_write_cond_eq = 1'b0;
    pc_write_cond_ne = 1'b0;
    i_or_d           = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    ir_write         = 1'b0;
    reg_dest         = 1'b0;
    reg_write        = 1'b0;
    mem_to_reg       = 1'b0;
    alu_src_a        = 1'b0;
    alu_src_b        = 2'b00;
    alu_op           = 2'b00;
    pc_source        = 2'b00;
    illegal_op       = 1'b0;
    bus_error        = 1'b0;
    instr_done       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        bus_error = timeout;
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = !(is_r || is_lw || is_sw || is_j || is_beq || is_bne || is_addi);
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        i_or_d    = 1'b1;
        mem_read  = 1'b1;
        bus_error = timeout;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        i_or_d     = 1'b1;
        mem_write  = 1'b1;
        bus_error  = timeout;
        instr_done = mem_ready;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_R_WB: begin
        reg_dest   = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a        = 1'b1;
        alu_op           = 2'b01;
        pc_source        = 2'b01;
        pc_write_cond_eq = is_beq;
        pc_write_cond_ne = is_bne;
        instr_done       = 1'b1;
      end
      S_JUMP: begin
        pc_source  = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    // Reset parks the FSM in FETCH; keep its strobes and event pulses quiet meanwhile.
    if (!rst_n) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      illegal_op = 1'b0;
      bus_error  = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign state       = state_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: builds the expected per-cycle trace of
// each instruction from its opcode class and chosen memory delays, then compares.
module tb_multicycle_control;

  localparam int WL = 15;

  localparam logic [5:0] OP_R    = 6'h2D;
  localparam logic [5:0] OP_LW   = 6'h2E;
  localparam logic [5:0] OP_SW   = 6'h2F;
  localparam logic [5:0] OP_J    = 6'h30;
  localparam logic [5:0] OP_BEQ  = 6'h31;
  localparam logic [5:0] OP_BNE  = 6'h32;
  localparam logic [5:0] OP_ADDI = 6'h33;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  opcode = 8'h00;
  logic        mem_ready = 1'b0;
  logic        pc_write, pc_write_cond_eq, pc_write_cond_ne, i_or_d, mem_read, mem_write;
  logic        ir_write, reg_dest, reg_write, mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic        illegal_op, bus_error, instr_done;
  logic [15:0] instr_count;

  multicycle_control #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond_eq(pc_write_cond_eq), .pc_write_cond_ne(pc_write_cond_ne),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dest(reg_dest), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .state(state), .illegal_op(illegal_op), .bus_error(bus_error), .instr_done(instr_done),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write, cond_eq, cond_ne, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dest, reg_write, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       illegal_op, bus_error, instr_done;
  } ctl_t;

  typedef struct {
    logic [3:0] st;
    bit         fixed;
    bit         rdy;
    ctl_t       ctl;
  } step_t;

  step_t       q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_count = 16'h0000;
  bit          all_ready = 1'b0;
  ctl_t        obs_ctl;

  assign obs_ctl = {pc_write, pc_write_cond_eq, pc_write_cond_ne, i_or_d, mem_read, mem_write,
                    ir_write, reg_dest, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                    pc_source, illegal_op, bus_error, instr_done};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [5:0] op);
    return (op >= 6'h2D) && (op <= 6'h33);
  endfunction

  function automatic void push(input logic [3:0] st, input bit fixed, input bit rdy, input ctl_t c);
    step_t s;
    s.st = st; s.fixed = fixed; s.rdy = rdy; s.ctl = c;
    q.push_back(s);
  endfunction

  // One memory-access phase: fd stalled cycles, then either completion or a timeout.
  function automatic bit mem_phase(input logic [3:0] st, input ctl_t base, input int d, input bit done_on_ready);
    ctl_t c;
    for (int i = 0; i < d && i < WL; i++) push(st, 1'b1, 1'b0, base);
    c = base;
    if (d > WL) begin
      c.bus_error = 1'b1;
      push(st, 1'b1, 1'b0, c);
      return 1'b0;
    end
    c.instr_done = done_on_ready;
    push(st, 1'b1, 1'b1, c);
    return 1'b1;
  endfunction

  function automatic void build(input logic [5:0] op, input int fd, input int md);
    ctl_t c;
    c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'b01;
    // the completing fetch cycle also raises ir_write/pc_write
    for (int i = 0; i < fd && i < WL; i++) push(4'd0, 1'b1, 1'b0, c);
    if (fd > WL) begin
      c.bus_error = 1'b1; push(4'd0, 1'b1, 1'b0, c); return;
    end
    c.ir_write = 1'b1; c.pc_write = 1'b1; push(4'd0, 1'b1, 1'b1, c);
    c = '0; c.alu_src_b = 2'b11;
    if (!legal(op)) begin
      c.illegal_op = 1'b1; push(4'd1, 1'b0, 1'b0, c); return;
    end
    push(4'd1, 1'b0, 1'b0, c);
    case (op)
      OP_LW, OP_SW: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; push(4'd2, 1'b0, 1'b0, c);
        c = '0; c.i_or_d = 1'b1;
        if (op == OP_SW) begin
          c.mem_write = 1'b1;
          void'(mem_phase(4'd5, c, md, 1'b1));
        end else begin
          c.mem_read = 1'b1;
          if (mem_phase(4'd3, c, md, 1'b0)) begin
            c = '0; c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1;
            push(4'd4, 1'b0, 1'b0, c);
          end
        end
      end
      OP_R: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_op = 2'b10; push(4'd6, 1'b0, 1'b0, c);
        c = '0; c.reg_dest = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1; push(4'd7, 1'b0, 1'b0, c);
      end
      OP_BEQ, OP_BNE: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_source = 2'b01; c.instr_done = 1'b1;
        c.cond_eq = (op == OP_BEQ); c.cond_ne = (op == OP_BNE);
        push(4'd8, 1'b0, 1'b0, c);
      end
      OP_J: begin
        c = '0; c.pc_source = 2'b10; c.pc_write = 1'b1; c.instr_done = 1'b1; push(4'd9, 1'b0, 1'b0, c);
      end
      default: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; push(4'd10, 1'b0, 1'b0, c);
        c = '0; c.reg_write = 1'b1; c.instr_done = 1'b1; push(4'd11, 1'b0, 1'b0, c);
      end
    endcase
  endfunction

  // Entered just after a rising edge; checks each cycle mid-period, before the next edge.
  task automatic run_instr(input logic [7:0] op8, input int fd, input int md, input int max_steps);
    int n;
    q.delete();
    build(op8[5:0], fd, md);
    $display("instr op=%02h fetch_wait=%0d mem_wait=%0d cycles=%0d count=%04h",
             op8, fd, md, q.size(), exp_count);
    n = 0;
    while (q.size() > 0 && n < max_steps) begin
      step_t s;
      s = q.pop_front();
      opcode = op8;
      mem_ready = s.fixed ? s.rdy : (all_ready ? 1'b1 : 1'($urandom_range(0, 1)));
      #4;
      chk($sformatf("state[%0d]", n), 32'(state), 32'(s.st));
      chk($sformatf("ctl[%0d] st=%0d", n, s.st), 32'(obs_ctl), 32'(s.ctl));
      chk($sformatf("instr_count[%0d]", n), 32'(instr_count), 32'(exp_count));
      @(posedge clk); #1;
      if (s.ctl.instr_done) exp_count = exp_count + 16'd1;
      n++;
    end
  endtask

  initial begin
    logic [7:0] op8;
    int         sel, fd, md;

    #2;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_count", 32'(instr_count), 32'd0);
    chk("reset_pulses", 32'({illegal_op, bus_error, instr_done}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    all_ready = 1'b1;
    run_instr(8'h2E, 0, 0, 1000);
    chk("lw_retired", 32'(instr_count), 32'd1);
    run_instr(8'h31, 0, 0, 1000);
    run_instr(8'h32, 0, 0, 1000);
    all_ready = 1'b0;
    run_instr(8'h2F, 0, 20, 1000);
    run_instr(8'h2F, 4, WL, 1000);
    run_instr(8'h00, 0, 0, 1000);
    run_instr(8'h2E, WL + 1, 0, 1000);
    run_instr(8'hF3, WL, 0, 1000);
    run_instr(8'h70, 1, 0, 1000);

    for (int k = 0; k < 200; k++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0: op8 = {2'($urandom_range(0, 3)), OP_R};
        1: op8 = {2'($urandom_range(0, 3)), OP_LW};
        2: op8 = {2'($urandom_range(0, 3)), OP_SW};
        3: op8 = {2'($urandom_range(0, 3)), OP_J};
        4: op8 = {2'($urandom_range(0, 3)), OP_BEQ};
        5: op8 = {2'($urandom_range(0, 3)), OP_BNE};
        6: op8 = {2'($urandom_range(0, 3)), OP_ADDI};
        default: begin
          op8 = 8'($urandom_range(0, 255));
          while (legal(op8[5:0])) op8 = 8'($urandom_range(0, 255));
        end
      endcase
      fd = ($urandom_range(0, 7) == 0) ? $urandom_range(WL - 1, WL + 2) : $urandom_range(0, 3);
      md = ($urandom_range(0, 5) == 0) ? $urandom_range(WL - 1, WL + 2) : $urandom_range(0, 3);
      run_instr(op8, fd, md, 1000);
    end

    // Asynchronous reset in the middle of a stalled load.
    run_instr(8'h2E, 0, 30, 5);
    chk("pre_reset_state", 32'(state), 32'd3);
    mem_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_state", 32'(state), 32'd0);
    chk("async_reset_count", 32'(instr_count), 32'd0);
    chk("reset_strobes", 32'({ir_write, pc_write, illegal_op, bus_error, instr_done}), 32'd0);
    @(posedge clk); #1;
    chk("held_reset_state", 32'(state), 32'd0);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    exp_count = 16'h0000;
    run_instr(8'h33, 0, 0, 1000);

    // Preload the counter just below wrap, then retire two R-type instructions.
    force dut.instr_count_q = 16'hFFFE;
    #1;
    release dut.instr_count_q;
    exp_count = 16'hFFFE;
    run_instr(8'h2D, 0, 0, 1000);
    chk("count_ffff", 32'(instr_count), 32'hFFFF);
    run_instr(8'h2D, 0, 0, 1000);
    chk("count_wrap", 32'(instr_count), 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter WAIT_LIMIT, default 15, SHALL set the maximum consecutive cycles without mem_ready tolerated in any memory-access state (range 1..255).
REQ-002 clk  input  1  single system clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 opcode  input  8  instruction opcode from the instruction register; only opcode[5:0] SHALL be decoded, opcode[7:6] ignored.
REQ-005 mem_ready  input  1  memory handshake; a read or write completes in the cycle it is high.
REQ-006 pc_write, pc_write_cond_eq, pc_write_cond_ne  output  1 each  unconditional and conditional PC update enables.
REQ-007 i_or_d, mem_read, mem_write, ir_write  output  1 each  memory address select (0 = PC, 1 = ALU out) and memory/IR strobes.
REQ-008 reg_dest, reg_write, mem_to_reg  output  1 each  register-file controls.
REQ-009 alu_src_a  output  1  (0 = PC, 1 = rs); alu_src_b  output  2  (00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm shifted left 2).
REQ-010 alu_op  output  2  (00 = add, 01 = subtract, 10 = funct-decoded); pc_source  output  2  (00 = ALU, 01 = ALU out, 10 = jump target).
REQ-011 state  output  4  current state encoding; illegal_op, bus_error, instr_done  output  1 each  single-cycle event pulses.
REQ-012 instr_count  output  16  count of retired instructions.

Function
REQ-013 Opcode decode on opcode[5:0] SHALL be: R-type 101101, lw 101110, sw 101111, j 110000, beq 110001, bne 110010, addi 110011; all other values are illegal.
REQ-014 State encoding SHALL be: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11; codes 12-15 SHALL transition to FETCH with all outputs at default.
REQ-015 Outputs not listed for a state SHALL be 0 (alu_src_b, alu_op, pc_source = 00).
REQ-016 FETCH: i_or_d=0, mem_read=1, alu_src_a=0, alu_src_b=01; when mem_ready=1, ir_write=1 and pc_write=1 in that same cycle and next state DECODE; otherwise stay.
REQ-017 DECODE: alu_src_a=0, alu_src_b=11; next state lw/sw->MEM_ADDR, R->R_EXEC, beq/bne->BRANCH, j->JUMP, addi->ADDI_EXEC; illegal->FETCH with illegal_op=1 during the DECODE cycle.
REQ-018 MEM_ADDR: alu_src_a=1, alu_src_b=10; lw->MEM_RD, sw->MEM_WR.
REQ-019 MEM_RD: i_or_d=1, mem_read=1; mem_ready=1 -> MEM_WB. MEM_WB: reg_write=1, mem_to_reg=1, reg_dest=0 -> FETCH.
REQ-020 MEM_WR: i_or_d=1, mem_write=1; mem_ready=1 -> FETCH.
REQ-021 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB: reg_dest=1, reg_write=1 -> FETCH.
REQ-022 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond_eq=1 for beq, pc_write_cond_ne=1 for bne -> FETCH.
REQ-023 JUMP: pc_source=10, pc_write=1 -> FETCH. ADDI_EXEC: alu_src_a=1, alu_src_b=10 -> ADDI_WB: reg_write=1, reg_dest=0 -> FETCH.
REQ-024 A wait counter SHALL clear on every state change and increment each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready=0.
REQ-025 When the wait counter equals WAIT_LIMIT and mem_ready=0, bus_error=1 for that cycle, no strobe other than the memory request is asserted, and next state SHALL be FETCH (FETCH re-enters with the counter cleared).
REQ-026 mem_ready=1 in the limit cycle SHALL complete normally with no bus_error.
REQ-027 instr_done=1 in the final cycle of MEM_WB, MEM_WR (with ready), R_WB, BRANCH, JUMP and ADDI_WB; instr_count SHALL increment by 1 in that cycle and wrap from 0xFFFF to 0x0000.
REQ-028 Illegal opcodes and bus errors SHALL NOT assert instr_done or increment instr_count.

Reset
REQ-029 rst_n=0 SHALL immediately force state=FETCH, clear the wait counter and set instr_count=0, regardless of clock or mid-instruction state.
REQ-030 After reset deassertion the first rising edge SHALL evaluate FETCH; no pulse output is asserted during reset.

Verification
REQ-031 lw (0x2E) with mem_ready always 1 -> states 0,1,2,3,4,0; instr_done in state 4; instr_count 0->1.
REQ-032 beq (0x31), then bne (0x32) -> BRANCH with only pc_write_cond_eq=1, then only pc_write_cond_ne=1; alu_op=01, pc_source=01.
REQ-033 sw (0x2F) with mem_ready held low for 20 cycles, WAIT_LIMIT=15 -> bus_error pulse at 16th MEM_WR cycle, return to FETCH, count unchanged.
REQ-034 opcode 0x00 in DECODE -> illegal_op=1 one cycle, next state FETCH, instr_count unchanged.
REQ-035 rst_n asserted low during MEM_RD -> state=0 and instr_count=0 without a clock edge.
REQ-036 instr_count preloaded to 0xFFFF by 65535 R-type (0x2D) instructions, one more -> instr_count=0x0000.
